// File: rtl/pipe_fetch_unit.sv
// Sequential instruction-fetch stage with a small PC/instruction queue toward ID.
// Optional combinational empty-queue bypass enabled by defining FETCH_BYPASS_EN.
module pipe_fetch_unit #(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          INST_W   = 32,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              clrn,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_inst,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc4
);

   localparam int unsigned       PTR_W   = $clog2(DEPTH);
   localparam int unsigned       CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] FOUR    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(3);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

   logic [INST_W-1:0] inst_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic              queue_empty;
   logic [CNT_W-1:0]  occupancy;
   logic              req;
   logic              bypass_hit;
   logic              bypass_take;
   logic              push;
   logic              pop;

   always_comb begin
      queue_empty = (count_q == '0);
      // Slots already promised to an outstanding response count as occupied.
      occupancy   = count_q + CNT_W'(inflight_q);
      req         = clrn && !redirect_valid && (occupancy < DEPTH_C);
`ifdef FETCH_BYPASS_EN
      bypass_hit  = clrn && !redirect_valid && queue_empty && inflight_q;
`else
      bypass_hit  = 1'b0;
`endif
      bypass_take = bypass_hit && id_ready;
      pop         = clrn && !queue_empty && id_ready;
      push        = inflight_q && !bypass_take;
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         inflight_d = 1'b0;
      end else begin
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         if (req) begin
            fetch_pc_d    = fetch_pc_q + FOUR;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end else begin
            inflight_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         fetch_pc_q    <= RESET_PC;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clrn && !redirect_valid && push) begin
         inst_q[wr_ptr_q] <= imem_rdata;
         pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
   end

   // Head outputs are forced to zero whenever nothing valid is presented.
   always_comb begin
      imem_req  = req;
      imem_addr = fetch_pc_q;
      id_valid  = 1'b0;
      id_inst   = '0;
      id_pc     = '0;
      id_pc4    = '0;
      if (clrn && !queue_empty) begin
         id_valid = 1'b1;
         id_inst  = inst_q[rd_ptr_q];
         id_pc    = pc_q[rd_ptr_q];
         id_pc4   = pc_q[rd_ptr_q] + FOUR;
      end else if (bypass_hit) begin
         id_valid = 1'b1;
         id_inst  = imem_rdata;
         id_pc    = inflight_pc_q;
         id_pc4   = inflight_pc_q + FOUR;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (clrn && !redirect_valid && push && !pop) begin
         assert (count_q < DEPTH_C)
            else $error("pipe_fetch_unit: enqueue into a full fetch queue");
      end
   end
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Randomised and directed bench for pipe_fetch_unit against a transaction-level queue model.
module tb_pipe_fetch_unit;

   localparam int          AW       = 32;
   localparam int          IW       = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP       = 1'b1;
   localparam int LAT_REQ   = 1;
   localparam int LAT_REDIR = 2;
`else
   localparam bit BYP       = 1'b0;
   localparam int LAT_REQ   = 2;
   localparam int LAT_REDIR = 3;
`endif

   logic          clk;
   logic          clrn;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          id_valid;
   logic          id_ready;
   logic [IW-1:0] id_inst;
   logic [AW-1:0] id_pc;
   logic [AW-1:0] id_pc4;

   pipe_fetch_unit #(
      .ADDR_W   (AW),
      .INST_W   (IW),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .clrn           (clrn),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Synchronous instruction memory with one-cycle read latency.
   initial imem_rdata = '0;
   always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_fetch_pc;
   bit          m_inflight;
   logic [31:0] m_ipc;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [129:0] exp_vec, obs_vec;
   logic [31:0]  got_pc[$];
   logic [31:0]  got_pc4[$];
   int           got_cyc[$];

   // Apply inputs for one cycle, predict outputs from the model and sample the DUT.
   task automatic drive(input bit rst_n, input bit rv, input logic [31:0] rpc, input bit rdy);
      bit          e_req, e_valid;
      logic [31:0] e_pc, e_inst;
      @(negedge clk);
      clrn = rst_n; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      #1;
      e_req   = rst_n && !rv && (mq.size() + int'(m_inflight) < DEPTH);
      e_valid = 1'b0; e_pc = '0; e_inst = '0;
      if (rst_n) begin
         if (mq.size() > 0) begin
            e_valid = 1'b1; e_pc = mq[0].pc; e_inst = mq[0].inst;
         end else if (BYP && m_inflight && !rv) begin
            e_valid = 1'b1; e_pc = m_ipc; e_inst = mem_word(m_ipc);
         end
      end
      exp_vec = {e_req, m_fetch_pc, e_valid, e_inst, e_pc, (e_valid ? e_pc + 32'd4 : 32'd0)};
      obs_vec = {imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4};
      if (id_valid && rdy && rst_n && !rv) begin
         got_pc.push_back(id_pc);
         got_pc4.push_back(id_pc4);
         got_cyc.push_back(cyc);
         $display("cyc %0d: id_pc=%h id_inst=%h id_pc4=%h", cyc, id_pc, id_inst, id_pc4);
      end
   endtask

   // Clock edge: advance the reference model with the inputs held for this cycle.
   task automatic advance();
      bit     was_empty, req;
      entry_t e;
      @(posedge clk);
      cyc++;
      if (!clrn) begin
         mq.delete(); m_inflight = 0; m_fetch_pc = RESET_PC;
      end else if (redirect_valid) begin
         mq.delete(); m_inflight = 0; m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         was_empty = (mq.size() == 0);
         req       = (mq.size() + int'(m_inflight) < DEPTH);
         if (!was_empty && id_ready) void'(mq.pop_front());
         if (m_inflight && !(BYP && was_empty && id_ready)) begin
            e.pc = m_ipc; e.inst = mem_word(m_ipc);
            mq.push_back(e);
         end
         if (req) begin
            m_inflight = 1; m_ipc = m_fetch_pc; m_fetch_pc = m_fetch_pc + 32'd4;
         end else begin
            m_inflight = 0;
         end
      end
   endtask

   task automatic clear_log();
      got_pc.delete(); got_pc4.delete(); got_cyc.delete();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         checks++;
         if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc4 !== 32'h0 || (i > 0 && imem_addr !== RESET_PC)) begin
            errors++; $display("FAIL reset_const cyc=%0d got req=%b valid=%b pc4=%h addr=%h exp 0/0/0/%h",
                               cyc, imem_req, id_valid, id_pc4, imem_addr, RESET_PC);
         end
         advance();
      end
   endtask

   task automatic test_sequential();
      int first_valid = -1;
      drive(0, 0, 32'h0, 1); advance();
      clear_log();
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 32'h0, 1);
         if (first_valid < 0 && id_valid) first_valid = i;
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL seq_stream cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      checks++;
      if (first_valid != LAT_REQ) begin
         errors++; $display("FAIL seq_latency got=%0d exp=%0d", first_valid, LAT_REQ);
      end
      checks++;
      if (got_pc.size() < 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8 ||
          got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1 || got_pc4[1] !== 32'h8) begin
         errors++; $display("FAIL seq_order got %0d entries first=%h exp 0,4,8 back-to-back", got_pc.size(),
                            (got_pc.size() > 0) ? got_pc[0] : 32'hX);
      end
   endtask

   task automatic test_stall();
      int nreq = 0;
      drive(0, 0, 32'h0, 0); advance();
      clear_log();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 32'h0, 0);
         if (imem_req) nreq++;
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      checks++;
      if (nreq != 4 || id_pc !== 32'h0) begin
         errors++; $display("FAIL stall_reqs got reqs=%0d id_pc=%h exp reqs=4 id_pc=0", nreq, id_pc);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL stall_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      checks++;
      if (got_pc.size() < 5 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8 ||
          got_pc[3] !== 32'hC || got_pc[4] !== 32'h10) begin
         errors++; $display("FAIL stall_order got %0d entries exp 0,4,8,C,10", got_pc.size());
      end
   endtask

   task automatic test_redirect();
      int first_valid = -1;
      bit stale = 0;
      drive(0, 0, 32'h0, 0); advance();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 32'h0, 0); advance();
      end
      clear_log();
      drive(1, 1, 32'h0000_1003, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++; $display("FAIL redir_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
      for (int k = 1; k < 8; k++) begin
         drive(1, 0, 32'h0, 1);
         if (first_valid < 0 && id_valid) first_valid = k;
         if (k == 1) begin
            checks++;
            if (id_valid !== 1'b0 || imem_addr !== 32'h1000) begin
               errors++; $display("FAIL redir_next got valid=%b addr=%h exp 0/00001000", id_valid, imem_addr);
            end
         end
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL redir_stream cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      foreach (got_pc[j]) if (got_pc[j] < 32'h1000 || got_pc[j] >= 32'h1040) stale = 1;
      checks++;
      if (first_valid != LAT_REDIR || got_pc.size() == 0 || got_pc[0] !== 32'h1000 || stale) begin
         errors++; $display("FAIL redir_target got lat=%0d first=%h stale=%0d exp lat=%0d first=00001000",
                            first_valid, (got_pc.size() > 0) ? got_pc[0] : 32'hX, stale, LAT_REDIR);
      end
   endtask

   task automatic test_back_to_back();
      bit stale = 0;
      drive(0, 0, 32'h0, 1); advance();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 32'h0, 1); advance();
      end
      clear_log();
      drive(1, 1, 32'h500, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++; $display("FAIL b2b_first cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
      drive(1, 1, 32'h200, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++; $display("FAIL b2b_second cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL b2b_stream cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      foreach (got_pc[j]) if (got_pc[j] < 32'h200 || got_pc[j] >= 32'h240) stale = 1;
      checks++;
      if (got_pc.size() == 0 || got_pc[0] !== 32'h200 || stale) begin
         errors++; $display("FAIL b2b_target got first=%h stale=%0d exp first=00000200 stale=0",
                            (got_pc.size() > 0) ? got_pc[0] : 32'hX, stale);
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 32'h0, 1); advance();
      clear_log();
      drive(1, 1, 32'hFFFF_FFF8, 1); advance();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL wrap_stream cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      checks++;
      if (got_pc.size() < 3 || got_pc[0] !== 32'hFFFF_FFF8 || got_pc[1] !== 32'hFFFF_FFFC ||
          got_pc[2] !== 32'h0 || got_pc4[0] !== 32'hFFFF_FFFC || got_pc4[1] !== 32'h0) begin
         errors++; $display("FAIL wrap_seq got %0d entries pc1=%h pc4_1=%h exp FFFFFFFC/00000000",
                            got_pc.size(), (got_pc.size() > 1) ? got_pc[1] : 32'hX,
                            (got_pc4.size() > 1) ? got_pc4[1] : 32'hX);
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 32'h0, 0); advance();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 32'h0, 0); advance();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec || id_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      clear_log();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'h0, 1);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL rst_restart cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
      end
      checks++;
      if (got_pc.size() < 2 || got_pc[0] !== RESET_PC || got_pc[1] !== RESET_PC + 32'd4) begin
         errors++; $display("FAIL rst_first got first=%h exp=%h",
                            (got_pc.size() > 0) ? got_pc[0] : 32'hX, RESET_PC);
      end
   endtask

   task automatic test_random();
      bit          rst_n, rv, rdy;
      logic [31:0] rpc;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         rv    = ($urandom_range(0, 15) == 0);
         rpc   = $urandom;
         rdy   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         drive(rst_n, rv, rpc, rdy);
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
         end
         advance();
         checks++;
         if (mq.size() > DEPTH) begin
            errors++; $display("FAIL random_occupancy got=%0d exp<=%0d", mq.size(), DEPTH);
         end
      end
   endtask

   initial begin
      clrn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      m_fetch_pc = RESET_PC; m_inflight = 0; m_ipc = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
